// File: rtl/aes_nibble_host.sv
// aes_nibble_host: host-side link controller for the nibble-serial AES core.
//
// It latches a 128-bit plaintext and key on an accepted start and pulses en.
// It then streams both operands out MSB nibble first over 32 cycles and waits
// for done. The 16 result bytes (MSB byte first) are reassembled into a
// 128-bit ciphertext.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (silent abort, no err)
//   start      transaction request, sampled only while idle
//   text_in    plaintext, latched on accepted start
//   key_in     key, latched on accepted start
//   test_mode  latched on accepted start, driven on test for the transaction
//   busy       high whenever a transaction is in flight
//   ct_out     last completed ciphertext, held until the next completion
//   ct_valid   one-cycle pulse when ct_out is updated
//   err        one-cycle pulse on WAIT timeout or done dropping during RECV
//   en         to core: one-cycle start pulse
//   test       to core: test-mode select
//   block      to core: plaintext nibble
//   key        to core: key nibble
//   done       from core: result byte valid
//   result     from core: ciphertext byte
//
// Every output is a register loaded with the value belonging to the next
// state. A value therefore appears in exactly the cycle the FSM sits in the
// matching state, and no combinational path runs from done/result to an output.

module aes_nibble_host #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] text_in,
    input  logic [127:0] key_in,
    input  logic         test_mode,
    output logic         busy,
    output logic [127:0] ct_out,
    output logic         ct_valid,
    output logic         err,
    output logic         en,
    output logic         test,
    output logic [3:0]   block,
    output logic [3:0]   key,
    input  logic         done,
    input  logic [7:0]   result
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Cycle in WAIT where the counter holds TIMEOUT_CYCLES: err is already
    // visible and the FSM leaves WAIT.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);
    // Last cycle in which done can still be accepted. Without done here, err is armed.
    localparam logic [TW-1:0] TMO_ARM  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t         state, state_d;
    logic [127:0]   text_q, text_d;     // plaintext, shifted left one nibble per send
    logic [127:0]   key_q, key_d;       // key, shifted alongside the plaintext
    logic           mode_q, mode_d;
    logic [4:0]     nib_cnt, nib_d;     // index of the nibble currently on block/key
    logic [3:0]     byte_cnt, byte_d;   // index of the next byte expected in RECV
    logic [TW-1:0]  tmo_cnt, tmo_d;
    logic [127:0]   ct_sr, sr_d;        // ciphertext assembly register

    logic           busy_d, ct_valid_d, err_d, en_d, test_d;
    logic [3:0]     block_d, key_out_d;
    logic [127:0]   ct_out_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d    = state;
        text_d     = text_q;
        key_d      = key_q;
        mode_d     = mode_q;
        nib_d      = nib_cnt;
        byte_d     = byte_cnt;
        tmo_d      = tmo_cnt;
        sr_d       = ct_sr;
        ct_out_d   = ct_out;
        en_d       = 1'b0;
        block_d    = 4'h0;
        key_out_d  = 4'h0;
        err_d      = 1'b0;
        ct_valid_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PULSE;
                    text_d  = text_in;
                    key_d   = key_in;
                    mode_d  = test_mode;
                    en_d    = 1'b1;
                end
            end

            S_PULSE: begin
                // Put nibble 31 on the link for the first SEND cycle.
                state_d   = S_SEND;
                block_d   = text_q[127:124];
                key_out_d = key_q[127:124];
                text_d    = {text_q[123:0], 4'h0};
                key_d     = {key_q[123:0], 4'h0};
                nib_d     = 5'd31;
            end

            S_SEND: begin
                if (nib_cnt == 5'd0) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end else begin
                    block_d   = text_q[127:124];
                    key_out_d = key_q[127:124];
                    text_d    = {text_q[123:0], 4'h0};
                    key_d     = {key_q[123:0], 4'h0};
                    nib_d     = nib_cnt - 5'd1;
                end
            end

            S_WAIT: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_d = S_IDLE;
                end else if (done) begin
                    // First byte is byte 15. After 16 left shifts it sits at 127:120.
                    sr_d    = {ct_sr[119:0], result};
                    byte_d  = 4'd14;
                    state_d = S_RECV;
                end else begin
                    tmo_d = tmo_cnt + 1'b1;
                    err_d = (tmo_cnt == TMO_ARM);
                end
            end

            S_RECV: begin
                if (done) begin
                    sr_d = {ct_sr[119:0], result};
                    if (byte_cnt == 4'd0) begin
                        state_d    = S_DONE;
                        ct_out_d   = {ct_sr[119:0], result};
                        ct_valid_d = 1'b1;
                    end else begin
                        byte_d = byte_cnt - 4'd1;
                    end
                end else begin
                    // A gap in the byte stream is a protocol error, so the
                    // partial ciphertext is discarded.
                    err_d   = 1'b1;
                    sr_d    = '0;
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        test_d = busy_d & mode_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= S_IDLE;
            text_q   <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            nib_cnt  <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            ct_sr    <= '0;
            ct_out   <= '0;
            busy     <= 1'b0;
            ct_valid <= 1'b0;
            err      <= 1'b0;
            en       <= 1'b0;
            test     <= 1'b0;
            block    <= 4'h0;
            key      <= 4'h0;
        end else begin
            state    <= state_d;
            text_q   <= text_d;
            key_q    <= key_d;
            mode_q   <= mode_d;
            nib_cnt  <= nib_d;
            byte_cnt <= byte_d;
            tmo_cnt  <= tmo_d;
            ct_sr    <= sr_d;
            ct_out   <= ct_out_d;
            busy     <= busy_d;
            ct_valid <= ct_valid_d;
            err      <= err_d;
            en       <= en_d;
            test     <= test_d;
            block    <= block_d;
            key      <= key_out_d;
        end
    end

endmodule

// File: tb/tb_aes_nibble_host.sv
// tb_aes_nibble_host: self-checking bench for aes_nibble_host.
//
// The bench acts as the core. It collects the nibble stream, replies with a
// byte stream after a chosen delay, and compares against a reference model.
// In the model, expected operands are rebuilt from nibble positions and the
// expected ciphertext is a weighted sum of the reply bytes. Inputs are driven
// and outputs sampled on the falling edge.

module tb_aes_nibble_host;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] text_in = '0;
    logic [127:0] key_in = '0;
    logic         test_mode = 1'b0;
    logic         busy;
    logic [127:0] ct_out;
    logic         ct_valid;
    logic         err;
    logic         en;
    logic         test;
    logic [3:0]   block;
    logic [3:0]   key;
    logic         done = 1'b0;
    logic [7:0]   result = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;
    int en_cnt   = 0;
    int err_cnt  = 0;
    int vld_cnt  = 0;
    logic [127:0] last_ct = '0;   // model of the ciphertext ct_out must hold

    aes_nibble_host #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .text_in   (text_in),
        .key_in    (key_in),
        .test_mode (test_mode),
        .busy      (busy),
        .ct_out    (ct_out),
        .ct_valid  (ct_valid),
        .err       (err),
        .en        (en),
        .test      (test),
        .block     (block),
        .key       (key),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Pulse counters used to prove "exactly one pulse" properties.
    always @(negedge clk) begin
        if (en)       en_cnt++;
        if (err)      err_cnt++;
        if (ct_valid) vld_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One transaction, entered on the falling edge of an idle cycle.
    // mode 0: full reply, 1: no reply (timeout), 2: done drops after nbytes.
    task automatic run_txn(input logic [127:0] txt, input logic [127:0] ky, input logic tm,
                           input int mode, input int delay, input int nbytes,
                           input logic [15:0][7:0] bytes, input bit spurious, input bit hold);
        int en0, err0, vld0;
        logic [127:0] got_blk, got_key, exp_ct;
        bit test_ok, early_err;
        en0 = en_cnt; err0 = err_cnt; vld0 = vld_cnt;
        got_blk = '0; got_key = '0; exp_ct = '0;
        test_ok = 1'b1; early_err = 1'b0;

        start = 1'b1; text_in = txt; key_in = ky; test_mode = tm;
        @(negedge clk);                                   // cycle E0+1
        check("pulse", {en, busy, test}, {1'b1, 1'b1, tm});
        start = hold;
        if (hold) begin text_in = ~txt; key_in = ~ky; test_mode = ~tm; end

        for (int n = 31; n >= 0; n--) begin
            @(negedge clk);                               // cycle E0+2+(31-n)
            got_blk[4*n +: 4] = block;
            got_key[4*n +: 4] = key;
            if (test !== tm || busy !== 1'b1) test_ok = 1'b0;
            done   = spurious ? 1'($urandom) : 1'b0;
            result = 8'($urandom);
        end
        done = 1'b0;
        @(negedge clk);                                   // cycle W = E0+34
        check("send_block", got_blk, txt);
        check("send_key", got_key, ky);
        check("send_test", 128'(test_ok), 128'd1);
        check("single_en", 128'(en_cnt - en0), 128'd1);
        check("wait_outs", {busy, en, block, key}, {1'b1, 1'b0, 8'h00});

        if (mode == 1) begin
            for (int k = 0; k < TMO; k++) begin
                if (err) early_err = 1'b1;
                @(negedge clk);
            end
            check("tmo_no_early_err", 128'(early_err), 128'd0);
            check("tmo_err", {err, busy}, 2'b11);         // cycle W+TMO
            @(negedge clk);
            check("tmo_idle", {busy, err, ct_valid, test}, 4'b0000);
            check("tmo_ct_hold", ct_out, last_ct);
            check("tmo_pulses", {32'(err_cnt - err0), 32'(vld_cnt - vld0)}, {32'd1, 32'd0});
        end else begin
            for (int k = 0; k < delay; k++) begin
                if (err) early_err = 1'b1;
                @(negedge clk);
            end
            for (int i = 0; i < nbytes; i++) begin
                done = 1'b1; result = bytes[i];
                @(negedge clk);
            end
            done = 1'b0; result = 8'($urandom);
            check("wait_no_early_err", 128'(early_err), 128'd0);
            if (mode == 0) begin
                for (int i = 0; i < 16; i++)
                    exp_ct = exp_ct + (128'(bytes[i]) << (8 * (15 - i)));
                check("done_flags", {ct_valid, busy, test}, {1'b1, 1'b1, tm});   // D+16
                check("done_ct", ct_out, exp_ct);
                @(negedge clk);                                               // D+17
                check("done_idle", {busy, ct_valid, test, err, en}, 5'b00000);
                check("done_pulses", {32'(vld_cnt - vld0), 32'(err_cnt - err0)}, {32'd1, 32'd0});
                last_ct = exp_ct;
            end else begin
                for (int k = 0; k < 4 && !err; k++) @(negedge clk);
                check("proto_err", {err, busy}, 2'b10);
                @(negedge clk);
                check("proto_idle", {busy, err, ct_valid}, 3'b000);
                check("proto_ct_hold", ct_out, last_ct);
                check("proto_pulses", {32'(err_cnt - err0), 32'(vld_cnt - vld0)}, {32'd1, 32'd0});
            end
        end
    endtask

    initial begin
        logic [15:0][7:0] bytes;
        int e0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outs", {busy, ct_valid, err, en, test, block, key}, 13'd0);
        check("reset_ct", ct_out, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic transfer: all-5 operands, test mode, reply 00..0F on the first WAIT cycle.
        for (int i = 0; i < 16; i++) bytes[i] = 8'(i);
        run_txn({32{4'h5}}, {32{4'h5}}, 1'b1, 0, 0, 16, bytes, 1'b0, 1'b0);
        check("basic_ct", ct_out, 128'h000102030405060708090A0B0C0D0E0F);

        // Nibble order.
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        run_txn(128'h0123456789ABCDEF_FEDCBA9876543210, {$urandom, $urandom, $urandom, $urandom},
                1'b0, 0, 3, 16, bytes, 1'b0, 1'b0);

        // Reset for two cycles in the middle of SEND, then a normal transaction.
        e0 = err_cnt;
        start = 1'b1; text_in = {4{$urandom}}; key_in = {4{$urandom}}; test_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {busy, ct_valid, err, en, test, block, key}, 13'd0);
        check("midrst_ct", ct_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        last_ct = '0;
        @(negedge clk);
        check("midrst_no_err", 128'(err_cnt - e0), 128'd0);
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b0, 0, 1, 16, bytes, 1'b0, 1'b0);

        // Timeout with no done at all.
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b1, 1, 0, 0, bytes, 1'b0, 1'b0);

        // Protocol error: done drops after five bytes.
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b0, 2, 2, 5, bytes, 1'b0, 1'b0);

        // Back-to-back with start held, changing inputs while busy, and spurious done during SEND.
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b1, 0, 2, 16, bytes, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b0, 0, 0, 16, bytes, 1'b1, 1'b0);

        // Random transactions. The first uses the latest accepted done (TMO-1 idle WAIT cycles).
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
            run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom), 0, (t == 0) ? TMO - 1 : int'($urandom_range(0, TMO - 1)), 16,
                    bytes, 1'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
